// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the five-frame UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StCleanup
  } state_t;

  localparam int unsigned FRAMES_PER_TXN       = 5;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

  // Byte sent in frame idx: word bytes LSB first, then the trailer.
  function automatic logic [7:0] txn_byte(input logic [31:0] word,
                                          input logic [7:0]  trailer,
                                          input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = word[7:0];
      3'd1:    b = word[15:8];
      3'd2:    b = word[23:16];
      3'd3:    b = word[31:24];
      default: b = trailer;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 frame serializer; a start at the end of the stop bit chains frames with no gap.
module uart_tx_byte
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       serial_o,
  output state_t     state_o,
  output logic       frame_done_o
);

  localparam logic [15:0] BitLast = 16'(CLKS_PER_BIT - 1);

  state_t      state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        serial_q;
  logic        bit_end;

  assign bit_end      = (baud_q == BitLast);
  assign frame_done_o = (state_q == StStop) && bit_end;
  assign serial_o     = serial_q;
  assign state_o      = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
    end else begin
      baud_q <= bit_end ? 16'd0 : baud_q + 16'd1;
      unique case (state_q)
        StIdle: begin
          baud_q   <= '0;
          bit_q    <= '0;
          serial_q <= 1'b1;
          if (start_i) begin
            state_q  <= StStart;
            shift_q  <= byte_i;
            serial_q <= 1'b0;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q  <= StData;
            bit_q    <= '0;
            serial_q <= shift_q[0];
            shift_q  <= {1'b0, shift_q[7:1]};
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_q == 3'(DATA_BITS - 1)) begin
              state_q  <= StStop;
              serial_q <= 1'b1;
            end else begin
              bit_q    <= bit_q + 3'd1;
              serial_q <= shift_q[0];
              shift_q  <= {1'b0, shift_q[7:1]};
            end
          end
        end
        StStop: begin
          if (bit_end) begin
            if (start_i) begin
              state_q  <= StStart;
              shift_q  <= byte_i;
              serial_q <= 1'b0;
            end else begin
              state_q  <= StIdle;
              serial_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Sends a 32-bit word (LSB byte first) plus a trailer byte as five back-to-back 8N1 frames.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] i_word,
  input  logic [7:0]  in_Byte,
  output logic        o_active,
  output logic        serial_out,
  output logic        r_done
);

  state_t      frame_state;
  state_t      state;
  logic        frame_done;
  logic        launch;
  logic        next_frame;
  logic        byte_start;
  logic [7:0]  byte_data;

  logic [2:0]  frame_q;
  logic [31:0] word_q;
  logic [7:0]  trailer_q;
  logic        active_q;
  logic        done_q;

  // CLEANUP is the single cycle after the last stop bit, while the serializer is already idle.
  assign state      = done_q ? StCleanup : frame_state;
  assign launch     = (state == StIdle) && enable;
  assign next_frame = frame_done && (frame_q != 3'(FRAMES_PER_TXN - 1));
  assign byte_start = launch || next_frame;
  assign byte_data  = launch ? i_word[7:0] : txn_byte(word_q, trailer_q, frame_q + 3'd1);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clock       (clock),
    .reset       (reset),
    .start_i     (byte_start),
    .byte_i      (byte_data),
    .serial_o    (serial_out),
    .state_o     (frame_state),
    .frame_done_o(frame_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_q   <= '0;
      word_q    <= '0;
      trailer_q <= '0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (launch) begin
        word_q    <= i_word;
        trailer_q <= in_Byte;
        frame_q   <= '0;
        active_q  <= 1'b1;
      end else if (frame_done) begin
        if (next_frame) begin
          frame_q <= frame_q + 3'd1;
        end else begin
          frame_q  <= '0;
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign o_active = active_q;
  assign r_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4; every line cycle is checked on the falling edge.
module tb_uart_tx;

  localparam int unsigned Cpb = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] i_word;
  logic [7:0]  in_Byte;
  logic        o_active;
  logic        serial_out;
  logic        r_done;

  int checks   = 0;
  int failures = 0;

  uart_tx #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .i_word    (i_word),
    .in_Byte   (in_Byte),
    .o_active  (o_active),
    .serial_out(serial_out),
    .r_done    (r_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_line(input string tag, input logic ser, input logic act, input logic done);
    chk({tag, ".serial"}, serial_out, ser);
    chk({tag, ".active"}, o_active, act);
    chk({tag, ".done"}, r_done, done);
  endtask

  // Checks the first nslots bit slots (start, 8 data LSB first, stop), each exactly Cpb cycles.
  task automatic expect_frame(input string tag, input logic [7:0] b, input int nslots);
    logic exp;
    for (int s = 0; s < nslots; s++) begin
      if (s == 0) exp = 1'b0;
      else if (s == 9) exp = 1'b1;
      else exp = b[s-1];
      for (int c = 0; c < Cpb; c++) begin
        chk_line($sformatf("%s.slot%0d.c%0d", tag, s, c), exp, 1'b1, 1'b0);
        @(negedge clock);
      end
    end
  endtask

  // Called on the first START cycle; ends on the cleanup cycle.
  task automatic expect_txn(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    expect_frame({tag, ".f0"}, b0, 10);
    expect_frame({tag, ".f1"}, b1, 10);
    expect_frame({tag, ".f2"}, b2, 10);
    expect_frame({tag, ".f3"}, b3, 10);
    expect_frame({tag, ".f4"}, b4, 10);
  endtask

  task automatic expect_cleanup(input string tag);
    chk_line({tag, ".cleanup"}, 1'b1, 1'b0, 1'b1);
    @(negedge clock);
    chk_line({tag, ".idle"}, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic launch(input logic [31:0] w, input logic [7:0] t, input logic hold);
    i_word  = w;
    in_Byte = t;
    enable  = 1'b1;
    @(negedge clock);
    if (!hold) enable = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    i_word  = 32'h0;
    in_Byte = 8'h0;

    // Reset held 3 cycles with enable high: no start bit.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk_line($sformatf("reset%0d", i), 1'b1, 1'b0, 1'b0);
    end
    reset  = 1'b0;
    enable = 1'b0;
    @(negedge clock);
    chk_line("post_reset", 1'b1, 1'b0, 1'b0);

    // Single pulsed transaction.
    launch(32'h041AF39B, 8'hA5, 1'b0);
    expect_txn("t1", 8'h9B, 8'hF3, 8'h1A, 8'h04, 8'hA5);
    expect_cleanup("t1");

    // Enable held: two transactions with a 2-cycle idle gap; enable dropped mid-second.
    @(negedge clock);
    launch(32'h00000000, 8'hFF, 1'b1);
    expect_txn("t2a", 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
    expect_cleanup("t2a");
    @(negedge clock);
    expect_frame("t2b.f0", 8'h00, 10);
    enable = 1'b0;
    expect_frame("t2b.f1", 8'h00, 10);
    expect_frame("t2b.f2", 8'h00, 10);
    expect_frame("t2b.f3", 8'h00, 10);
    expect_frame("t2b.f4", 8'hFF, 10);
    expect_cleanup("t2b");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk_line($sformatf("t2.quiet%0d", i), 1'b1, 1'b0, 1'b0);
    end

    // Input word changed during frame 2 must not affect the transaction.
    launch(32'hC3A55A81, 8'h7E, 1'b0);
    expect_frame("t3.f0", 8'h81, 10);
    i_word  = 32'hFFFFFFFF;
    in_Byte = 8'h00;
    expect_frame("t3.f1", 8'h5A, 10);
    expect_frame("t3.f2", 8'hA5, 10);
    expect_frame("t3.f3", 8'hC3, 10);
    expect_frame("t3.f4", 8'h7E, 10);
    expect_cleanup("t3");

    // Reset in the middle of frame 3's data bits.
    @(negedge clock);
    launch(32'h12345678, 8'h3C, 1'b0);
    expect_frame("t4.f0", 8'h78, 10);
    expect_frame("t4.f1", 8'h56, 10);
    expect_frame("t4.f2", 8'h34, 5);
    reset = 1'b1;
    @(negedge clock);
    chk_line("t4.reset", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk_line($sformatf("t4.after%0d", i), 1'b1, 1'b0, 1'b0);
    end

    // Fresh transaction after reset; 8'h55 bytes exercise per-bit width.
    launch(32'h55AA33CC, 8'h55, 1'b0);
    expect_txn("t5", 8'hCC, 8'h33, 8'hAA, 8'h55, 8'h55);
    expect_cleanup("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 clock  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  request to start a transaction; level-sensitive, sampled only in IDLE.
REQ-005 i_word  input  32  word to transmit as four bytes.
REQ-006 in_Byte  input  8  trailer byte sent after the four word bytes.
REQ-007 o_active  output  1  high while a transaction is on the line.
REQ-008 serial_out  output  1  UART line; idle high.
REQ-009 r_done  output  1  one-cycle pulse at transaction completion.

Function
REQ-010 Frame format: 8N1, i.e. 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-011 Transaction: 5 frames, sent back-to-back with no idle gap: i_word[7:0], [15:8], [23:16], [31:24], then in_Byte.
REQ-012 i_word and in_Byte are captured into internal registers on the edge that leaves IDLE; later input changes do not affect the running transaction.
REQ-013 States: IDLE, START, DATA, STOP, CLEANUP; 3-bit encoding.
REQ-014 IDLE -> START when enable=1 at a rising edge; otherwise stay in IDLE.
REQ-015 START -> DATA after CLKS_PER_BIT cycles; DATA -> STOP after 8 bits; STOP -> START if frames remain, STOP -> CLEANUP after the 5th frame.
REQ-016 CLEANUP lasts 1 cycle, then the FSM goes to IDLE.
REQ-017 serial_out is registered and shows start bit 0 in the first cycle of START, i.e. one cycle after enable is sampled.
REQ-018 o_active is 1 in START, DATA and STOP, and 0 in IDLE and CLEANUP.
REQ-019 r_done is 1 only during CLEANUP (exactly one cycle per transaction).
REQ-020 Transaction duration, from first start-bit cycle to last stop-bit cycle, is exactly 50*CLKS_PER_BIT cycles.
REQ-021 If enable is held high, the next transaction starts on the edge after IDLE is entered, giving a 2-cycle idle-high gap (CLEANUP + IDLE).
REQ-022 Deasserting enable mid-transaction has no effect; the transaction completes.
REQ-023 The baud counter is 16 bits and resets to 0 at each bit boundary; the bit index is 3 bits and the frame index is 3 bits (0..4).

Reset
REQ-024 Reset forces state IDLE, serial_out=1, o_active=0, r_done=0, and clears all counters and captured data, from any state (including mid-frame) on the next edge.
REQ-025 Reset has priority over enable.

Structure
REQ-026 Shared package uart_tx_pkg holds the state enum, FRAMES_PER_TXN=5, DATA_BITS=8, and the default CLKS_PER_BIT.
REQ-027 One sub-module is natural: uart_tx_byte, a single-frame serializer (start/data/stop plus baud counter) with a start input and a frame-done output; uart_tx sequences five frames through it.

Verification (CLKS_PER_BIT=4)
REQ-028 Reset is asserted for 3 cycles -> serial_out=1, o_active=0, r_done=0 throughout; enable=1 during reset produces no start bit.
REQ-029 i_word=32'h041AF39B, in_Byte=8'hA5, enable pulsed 1 cycle -> decoded bytes 9B, F3, 1A, 04, A5 in order; o_active high for 200 cycles; a single r_done pulse follows.
REQ-030 enable held high with i_word=32'h00000000 and in_Byte=8'hFF -> consecutive transactions separated by exactly 2 idle-high cycles, with one r_done pulse per transaction.
REQ-031 i_word is changed to 32'hFFFFFFFF during the second frame -> the transmitted bytes remain those captured at the start.
REQ-032 Reset is asserted during the third frame's DATA state -> the next cycle shows serial_out=1, o_active=0 and no r_done pulse; a new transaction after release is correct.
REQ-033 Every bit is checked for width: each bit of the 8'h55 byte is exactly 4 cycles wide and the stop bit is 1.
